mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential 32-bit multiply/divide unit: shift-add multiply, restoring divide, signed via magnitudes.
// Latency: start accepted at edge N -> done and HI/LO updated at edge N+33 (disabled divide: N+1).
// Backpressure: start is ignored while busy=1; accepted again in the done cycle (busy=0).
// Build option: define MDU_DIV_EN to compile in the divide datapath (ops 10/11).
module mdu_seq (
    input  logic        clk_Regs,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd31;

    state_t      state_q;
    logic [4:0]  cnt_q;
    // Shared 64-bit work register: {partial product} for multiply,
    // {remainder, dividend/quotient shift} for divide.
    logic [63:0] prod_q;
    // Operand held constant during RUN: multiplicand magnitude or divisor magnitude.
    logic [31:0] opnd_q;
    // Negate product (multiply) or quotient (divide) in FIN.
    logic        neg_res_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

`ifdef MDU_DIV_EN
    logic        is_div_q;
    logic        div0_q;
    logic        neg_rem_q;
    logic [31:0] a_raw_q;
`else
    // Divide ops are accepted but produce no result in this build.
    logic        skip_q;
`endif

    // Operand magnitudes, formed only for the signed ops (op[0]=1).
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // One shift-add multiply step.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_fix;

    logic [63:0] step_d;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`endif

    // Operand magnitudes and the per-iteration datapath step.
    always_comb begin
        mag_a    = (op[0] && A[31]) ? (~A + 32'd1) : A;
        mag_b    = (op[0] && B[31]) ? (~B + 32'd1) : B;

        // Add multiplicand when the current multiplier bit is set, then shift right,
        // so the multiplier drains out of the low half as the product fills in.
        mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, prod_q[31:1]};
        mul_fix  = neg_res_q ? (~prod_q + 64'd1) : prod_q;

`ifdef MDU_DIV_EN
        // Restoring step: shift next dividend bit into the remainder, keep the
        // difference if it did not borrow, and shift the quotient bit in at the bottom.
        div_shift = {prod_q[63:32], prod_q[31]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_trial[32];
        div_rem   = div_ok ? div_trial[31:0] : div_shift[31:0];
        div_next  = {div_rem, prod_q[30:0], div_ok};
        quo_fix   = neg_res_q ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
        rem_fix   = neg_rem_q ? (~prod_q[63:32] + 32'd1) : prod_q[63:32];

        step_d = is_div_q ? div_next : mul_next;
        if (!is_div_q) begin
            res_hi = mul_fix[63:32];
            res_lo = mul_fix[31:0];
        end else if (div0_q) begin
            // Divide by zero returns the raw dividend and an all-ones quotient.
            res_hi = a_raw_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
`else
        step_d = mul_next;
        res_hi = mul_fix[63:32];
        res_lo = mul_fix[31:0];
`endif
    end

    // Control FSM IDLE -> RUN -> FIN -> IDLE with registered busy/done/HI/LO.
    always_ff @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            prod_q    <= 64'd0;
            opnd_q    <= 32'd0;
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
`ifdef MDU_DIV_EN
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_rem_q <= 1'b0;
            a_raw_q   <= 32'd0;
`else
            skip_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q     <= 5'd0;
                        busy_q    <= 1'b1;
                        neg_res_q <= op[0] & (A[31] ^ B[31]);
`ifdef MDU_DIV_EN
                        is_div_q  <= op[1];
                        div0_q    <= op[1] & (B == 32'd0);
                        neg_rem_q <= op[1] & op[0] & A[31];
                        a_raw_q   <= A;
                        if (op[1]) begin
                            opnd_q <= mag_b;
                            prod_q <= {32'd0, mag_a};
                        end else begin
                            opnd_q <= mag_a;
                            prod_q <= {32'd0, mag_b};
                        end
                        state_q <= S_RUN;
`else
                        skip_q <= op[1];
                        opnd_q <= mag_a;
                        prod_q <= {32'd0, mag_b};
                        if (op[1]) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_RUN;
                        end
`endif
                    end
                end
                S_RUN: begin
                    prod_q <= step_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
`ifdef MDU_DIV_EN
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
`else
                    if (!skip_q) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table plus hand sequences for reset abort, busy-ignore and back-to-back.
// Results are checked by a monitor popping an expected-result queue on each done pulse.
// Divide expectations follow the MDU_DIV_EN build option.
module tb_mdu_seq;

    logic        clk_Regs = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk_Regs = ~clk_Regs;

    mdu_seq dut (
        .clk_Regs(clk_Regs),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        done_prev = 1'b0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    always @(posedge clk_Regs) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mul_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (o[0]) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Result monitor: every done pulse must match the oldest expected result.
    always @(posedge clk_Regs) begin : mon
        exp_t e;
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            check("done_pulse_width", {63'd0, done_prev}, 64'd0);
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                e = sbq.pop_front();
                check("HI", {32'd0, HI}, {32'd0, e.hi});
                check("LO", {32'd0, LO}, {32'd0, e.lo});
                check("latency_cycle", 64'(cyc), 64'(e.due));
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
        done_prev = done;
    end

    // Wait for an idle slot, pulse start for one edge, queue the expected result,
    // then scramble the inputs so in-flight results must not depend on them.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, output int acc);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk_Regs);
        while (busy !== 1'b0 && w < 200) begin
            @(negedge clk_Regs);
            w++;
        end
        check("idle_before_start", {63'd0, busy}, 64'd0);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk_Regs);
        start = 1'b0;
        acc   = cyc;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
`ifndef MDU_DIV_EN
        if (o[1]) begin
            e = '{hi: mdl_hi, lo: mdl_lo, due: acc + 1};
        end else begin
            e = '{hi: ehi, lo: elo, due: acc + 33};
        end
`else
        e = '{hi: ehi, lo: elo, due: acc + 33};
`endif
        sbq.push_back(e);
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        A  = $urandom;
        B  = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge clk_Regs);
            w++;
        end
        check("pending_results", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    initial begin
        int a1;
        int a2;
        int snap;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        logic [63:0] p;

        tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        tbl.push_back('{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        tbl.push_back('{2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000});
        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
        tbl.push_back('{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
        tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tbl.push_back('{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
        tbl.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        tbl.push_back('{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});
        tbl.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
        tbl.push_back('{2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F});
        tbl.push_back('{2'b10, 32'h0000_0064, 32'h0000_0002, 32'h0000_0000, 32'h0000_0032});

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_HI", {32'd0, HI}, 64'd0);
        check("reset_LO", {32'd0, LO}, 64'd0);
        @(negedge clk_Regs);
        rst_n = 1'b1;

        // Vector table, issued back-to-back as soon as the unit goes idle.
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, a1);
        end
        drain();

        // Back-to-back: second start lands in the done cycle of the first.
        issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, a1);
        issue(2'b00, 32'd4, 32'd5, 32'd0, 32'd20, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'd34);
        drain();

        // Start pulsed while busy must be ignored.
        issue(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, a1);
        repeat (10) @(negedge clk_Regs);
        op = 2'b01; A = 32'hDEAD_BEEF; B = 32'h0000_0003; start = 1'b1;
        @(negedge clk_Regs);
        start = 1'b0;
        drain();

        // Random multiplies against a 64-bit arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 1));
            p  = mul_model(ro, ra, rb);
            issue(ro, ra, rb, p[63:32], p[31:0], a1);
        end
        drain();

        // Reset mid-operation aborts with no done pulse and clears HI/LO at once.
        issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, a1);
        repeat (9) @(negedge clk_Regs);
        op = 2'b00; A = 32'd11; B = 32'd13; start = 1'b1;
        @(negedge clk_Regs);
        start = 1'b0;
        while (cyc < a1 + 20) @(negedge clk_Regs);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_HI", {32'd0, HI}, 64'd0);
        check("abort_LO", {32'd0, LO}, 64'd0);
        snap = done_cnt;
        repeat (2) @(negedge clk_Regs);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_Regs);
        check("no_done_after_abort", 64'(done_cnt - snap), 64'd0);
        check("HI_held_after_abort", {32'd0, HI}, 64'd0);
        issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, a1);
        drain();

        repeat (3) @(negedge clk_Regs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
